// File: rtl/spi_flash_responder.sv
// SPI flash responder: oversamples the flash pins on clk, decodes READ (0x03),
// FAST READ (0x0B) and JEDEC ID (0x9F), and serves bytes from a synchronous byte memory.
module spi_flash_responder #(
  parameter int          ADDR_WIDTH = 24,
  parameter logic [23:0] JEDEC_ID   = 24'hEF4016
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flash_csb,
  input  logic                  flash_clk,
  input  logic                  flash_io0,
  output logic                  flash_io1_do,
  output logic                  flash_io1_oe,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_rdata,
  output logic                  busy,
  output logic [2:0]            dbg_state
);

  // Memory handshake: mem_rd is a one-cycle strobe with mem_addr; mem_rdata is
  // valid exactly one cycle later; only one read is ever outstanding.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DUMMY  = 3'd3,
    DATA   = 3'd4,
    ID     = 3'd5,
    IGNORE = 3'd6
  } state_t;

  state_t      state;
  logic [1:0]  csb_s, clk_s, io0_s;
  logic        csb_d, clk_d;
  logic        csb_q, io0_q, sclk_rise, sclk_fall, csb_fall;
  logic [22:0] rx;
  logic [23:0] rx_next;
  logic [4:0]  bit_cnt;
  logic        dummy_en;
  logic [7:0]  tx_sr, nxt;
  logic [2:0]  tx_cnt;
  logic [1:0]  id_idx;
  logic        pf_req, rd_dst, cap, cap_dst;

  assign csb_q     = csb_s[1];
  assign io0_q     = io0_s[1];
  assign sclk_rise = clk_s[1] & ~clk_d;
  assign sclk_fall = ~clk_s[1] & clk_d;
  assign csb_fall  = csb_d & ~csb_q;
  assign rx_next   = {rx, io0_q};
  assign dbg_state = state;

  function automatic logic [7:0] id_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    id_byte = JEDEC_ID[23:16];
      2'd1:    id_byte = JEDEC_ID[15:8];
      default: id_byte = JEDEC_ID[7:0];
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csb_s <= 2'b11;
      csb_d <= 1'b1;
      clk_s <= 2'b00;
      clk_d <= 1'b0;
      io0_s <= 2'b00;
    end else begin
      csb_s <= {csb_s[0], flash_csb};
      csb_d <= csb_s[1];
      clk_s <= {clk_s[0], flash_clk};
      clk_d <= clk_s[1];
      io0_s <= {io0_s[0], flash_io0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rx           <= '0;
      bit_cnt      <= '0;
      dummy_en     <= 1'b0;
      tx_sr        <= '0;
      nxt          <= '0;
      tx_cnt       <= '0;
      id_idx       <= '0;
      pf_req       <= 1'b0;
      rd_dst       <= 1'b0;
      cap          <= 1'b0;
      cap_dst      <= 1'b0;
      mem_rd       <= 1'b0;
      mem_addr     <= '0;
      flash_io1_do <= 1'b0;
      flash_io1_oe <= 1'b0;
      busy         <= 1'b0;
    end else begin
      busy    <= ~csb_q;
      mem_rd  <= 1'b0;
      cap     <= mem_rd;
      cap_dst <= rd_dst;
      if (csb_q) begin
        // Deselected: drop everything, including a read whose data is still in flight.
        state        <= IDLE;
        rx           <= '0;
        bit_cnt      <= '0;
        dummy_en     <= 1'b0;
        tx_sr        <= '0;
        nxt          <= '0;
        tx_cnt       <= '0;
        id_idx       <= '0;
        pf_req       <= 1'b0;
        cap          <= 1'b0;
        flash_io1_do <= 1'b0;
        flash_io1_oe <= 1'b0;
      end else begin
        if (cap) begin
          if (cap_dst) begin
            nxt <= mem_rdata;
          end else begin
            tx_sr  <= mem_rdata;
            pf_req <= 1'b1;
          end
        end
        if (pf_req) begin
          mem_rd   <= 1'b1;
          mem_addr <= mem_addr + ADDR_WIDTH'(1);
          rd_dst   <= 1'b1;
          pf_req   <= 1'b0;
        end
        case (state)
          IDLE: if (csb_fall) begin
            state   <= CMD;
            bit_cnt <= '0;
          end
          CMD: if (sclk_rise) begin
            rx      <= rx_next[22:0];
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              case (rx_next[7:0])
                8'h03: begin state <= ADDR; dummy_en <= 1'b0; end
                8'h0B: begin state <= ADDR; dummy_en <= 1'b1; end
                8'h9F: begin
                  state        <= ID;
                  tx_sr        <= JEDEC_ID[23:16];
                  id_idx       <= 2'd1;
                  tx_cnt       <= '0;
                  flash_io1_oe <= 1'b1;
                end
                default: state <= IGNORE;
              endcase
            end
          end
          ADDR: if (sclk_rise) begin
            rx      <= rx_next[22:0];
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd23) begin
              bit_cnt  <= '0;
              mem_rd   <= 1'b1;
              mem_addr <= rx_next[ADDR_WIDTH-1:0];
              rd_dst   <= 1'b0;
              tx_cnt   <= '0;
              if (dummy_en) begin
                state <= DUMMY;
              end else begin
                state        <= DATA;
                flash_io1_oe <= 1'b1;
              end
            end
          end
          DUMMY: if (sclk_rise) begin
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              bit_cnt      <= '0;
              state        <= DATA;
              flash_io1_oe <= 1'b1;
            end
          end
          DATA, ID: if (sclk_fall) begin
            flash_io1_do <= tx_sr[7];
            tx_sr        <= {tx_sr[6:0], 1'b0};
            tx_cnt       <= tx_cnt + 3'd1;
            // Last bit of the byte is out: queue the next byte for the following fall.
            if (tx_cnt == 3'd7) begin
              if (state == DATA) begin
                tx_sr  <= nxt;
                pf_req <= 1'b1;
              end else begin
                tx_sr  <= id_byte(id_idx);
                id_idx <= (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
